// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared FSM encoding and counter-width helper for the sequential multiplier
//
// Purpose : state encoding constants, the FSM state type and the helper that
//           sizes the iteration counter.
// Ports   : none (package)

package mult_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

    // The counter is loaded with WIDTH+1, so it needs room for values up to WIDTH+1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one combinational radix-2 Booth iteration
//
// Purpose : given the accumulator {A, Q, q_1} and multiplicand M (both N bits
//           wide), add/subtract/skip M into A according to {Q[0], q_1}, then
//           arithmetic-shift the whole accumulator right by one.
// Ports   : acc      in  [2N:0]  current {A, Q, q_1}
//           m        in  [N-1:0] multiplicand (already extended)
//           acc_next out [2N:0]  accumulator after this step

module booth_step #(
    parameter int N = 33
) (
    input  logic [2*N:0] acc,
    input  logic [N-1:0] m,
    output logic [2*N:0] acc_next
);

    logic [N:0] hi;
    logic [N:0] m_ext;
    logic [N:0] sum;

    // The add/sub is done one bit wider than A so the true sign of the sum is
    // what gets shifted in; no intermediate overflow is possible.
    always_comb begin
        hi    = {acc[2*N], acc[2*N:N+1]};
        m_ext = {m[N-1], m};
        sum   = hi;
        case (acc[1:0])
            2'b01:   sum = hi + m_ext;
            2'b10:   sum = hi - m_ext;
            default: sum = hi;
        endcase
        // Dropping the old q_1 is the shift: new A = sum[N:1], new Q = {sum[0], Q[N-1:1]}, new q_1 = Q[0].
        acc_next = {sum, acc[N:1]};
    end

endmodule

// File: rtl/seq_mult_param.sv
// rtl/seq_mult_param.sv - sequential radix-2 Booth multiplier, signed or unsigned
//
// Purpose : multiplies two WIDTH-bit operands in a fixed WIDTH+1 cycles,
//           producing the exact 2*WIDTH-bit product.
// Ports   : clk        in   clock, rising edge
//           rst        in   asynchronous active-low reset
//           start      in   request a multiply (ignored while busy)
//           is_signed  in   1 = two's-complement operands, 0 = unsigned
//           a, b       in   [WIDTH-1:0] multiplicand / multiplier
//           p          out  [2*WIDTH-1:0] product, held until next completion
//           busy       out  high while an operation runs
//           done       out  one-cycle pulse when p has just been updated

module seq_mult_param
    import mult_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy,
    output logic                 done
);

    // One extra bit lets both signed and unsigned operands be treated as signed.
    localparam int N     = WIDTH + 1;
    localparam int ACC_W = 2 * N + 1;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [N-1:0]       m;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_next;
    logic [N-1:0]       a_ext;
    logic [N-1:0]       b_ext;

    assign a_ext = {is_signed & a[WIDTH-1], a};
    assign b_ext = {is_signed & b[WIDTH-1], b};

    booth_step #(.N(N)) u_step (
        .acc      (acc),
        .m        (m),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            m     <= '0;
            acc   <= '0;
            p     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        m     <= a_ext;
                        acc   <= {{N{1'b0}}, b_ext, 1'b0};
                        cnt   <= CNT_W'(N);
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt - CNT_W'(1);
                    // cnt==1 means this edge performs the final step.
                    if (cnt == CNT_W'(1)) begin
                        p     <= acc_next[2*WIDTH:1];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_param.sv
// tb/tb_seq_mult_param.sv - self-checking bench for seq_mult_param (WIDTH=32 and WIDTH=8)

module tb_seq_mult_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, is_signed;
    logic [31:0] a, b;
    logic [63:0] p;
    logic        busy, done;

    logic        start8, is_signed8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    logic        busy8, done8;

    int n_pass  = 0;
    int n_total = 0;

    seq_mult_param #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
        .a(a), .b(b), .p(p), .busy(busy), .done(done)
    );

    seq_mult_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .is_signed(is_signed8),
        .a(a8), .b(b8), .p(p8), .busy(busy8), .done(done8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [63:0] ref32(input logic s, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy;
        if (s) begin
            sx = $signed({{32{x[31]}}, x});
            sy = $signed({{32{y[31]}}, y});
            return sx * sy;
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

    function automatic logic [15:0] ref8(input logic s, input logic [7:0] x, input logic [7:0] y);
        logic signed [15:0] sx, sy;
        if (s) begin
            sx = $signed({{8{x[7]}}, x});
            sy = $signed({{8{y[7]}}, y});
            return sx * sy;
        end
        return {8'b0, x} * {8'b0, y};
    endfunction

    // Drive a request (caller is off-edge), wait for done, report product and latency.
    task automatic op32(input logic s, input logic [31:0] x, input logic [31:0] y,
                        output logic [63:0] pr, output int lat);
        is_signed = s; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", {63'b0, busy}, 64'd1);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        pr = p;
    endtask

    task automatic run32(input string name, input logic s, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] pr;
        int lat;
        op32(s, x, y, pr, lat);
        chk({name, "_lat"}, 64'(lat), 64'd33);
        chk({name, "_p"}, pr, ref32(s, x, y));
        chk({name, "_busy_done"}, {63'b0, busy}, 64'd0);
    endtask

    task automatic run8(input string name, input logic s, input logic [7:0] x, input logic [7:0] y);
        int lat;
        is_signed8 = s; a8 = x; b8 = y; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_lat"}, 64'(lat), 64'd9);
        chk({name, "_p"}, {48'b0, p8}, {48'b0, ref8(s, x, y)});
    endtask

    typedef struct {
        string       name;
        logic        s;
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [63:0] pr;
        int lat;
        logic        rs;
        logic [31:0] rx, ry;

        rst = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        start8 = 1'b0; is_signed8 = 1'b0; a8 = '0; b8 = '0;

        vecs.push_back('{"s_20x75",       1'b1, 32'd20,         32'd75,         64'd1500});
        vecs.push_back('{"s_neg_neg",     1'b1, 32'hFFFFFFD5,   32'hFFFFFFD0,   64'd2064});
        vecs.push_back('{"s_pos_neg",     1'b1, 32'd23,         32'hFFFFFFF1,   64'hFFFFFFFFFFFFFEA7});
        vecs.push_back('{"u_max_max",     1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFE00000001});
        vecs.push_back('{"s_m1_m1",       1'b1, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'd1});
        vecs.push_back('{"s_min_min",     1'b1, 32'h80000000,   32'h80000000,   64'h4000000000000000});
        vecs.push_back('{"u_msb_msb",     1'b0, 32'h80000000,   32'h80000000,   64'h4000000000000000});
        vecs.push_back('{"s_max_min",     1'b1, 32'h7FFFFFFF,   32'h80000000,   64'hC000000080000000});
        vecs.push_back('{"u_max_msb",     1'b0, 32'hFFFFFFFF,   32'h80000000,   64'h7FFFFFFF80000000});
        vecs.push_back('{"zero",          1'b1, 32'd0,          32'd12345,      64'd0});

        repeat (3) @(posedge clk);
        #1;
        chk("rst_p",     p,                    64'd0);
        chk("rst_busy",  {63'b0, busy},        64'd0);
        chk("rst_done",  {63'b0, done},        64'd0);
        chk("rst_p8",    {48'b0, p8},          64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Table vectors, issued back-to-back (each start lands in the DONE cycle).
        foreach (vecs[i]) begin
            op32(vecs[i].s, vecs[i].x, vecs[i].y, pr, lat);
            chk({vecs[i].name, "_lat"}, 64'(lat), 64'd33);
            chk({vecs[i].name, "_p"}, pr, vecs[i].exp);
        end
        // Without a new start, DONE lasts one cycle and the product holds.
        @(posedge clk); #1;
        chk("done_pulse_width", {63'b0, done}, 64'd0);
        chk("idle_busy",        {63'b0, busy}, 64'd0);
        chk("p_held",           p,             64'd0);

        // Random operands against the arithmetic model.
        for (int i = 0; i < 24; i++) begin
            rs = 1'($urandom_range(0, 1));
            rx = $urandom;
            ry = $urandom;
            if (i % 6 == 0) rx = 32'h80000000;
            run32("rand32", rs, rx, ry);
        end

        // 8-bit instance.
        run8("w8_s_min", 1'b1, 8'h80, 8'h80);
        run8("w8_u_msb", 1'b0, 8'h80, 8'h80);
        for (int i = 0; i < 8; i++)
            run8("rand8", 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));

        // Start and operand changes during RUN are ignored.
        @(negedge clk);
        is_signed = 1'b1; a = 32'd125; b = 32'hFFFFFFEE; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 10) begin
                start = 1'b1; a = 32'd7; b = 32'd7; is_signed = 1'b0;
            end else if (lat == 11) begin
                start = 1'b0;
            end
        end
        chk("ignore_start_lat", 64'(lat), 64'd33);
        chk("ignore_start_p", p, 64'hFFFFFFFFFFFFF736);

        // Reset in the middle of an operation aborts it.
        @(posedge clk); #1;
        is_signed = 1'b1; a = 32'd99; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #1;
        chk("abort_p",    p,             64'd0);
        chk("abort_busy", {63'b0, busy}, 64'd0);
        chk("abort_done", {63'b0, done}, 64'd0);
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (i == 2) rst = 1'b1;
            if (done) chk("abort_no_done", {63'b0, done}, 64'd0);
        end
        run32("after_reset", 1'b1, 32'd10, 32'd1);
        chk("after_reset_abs", p, 64'd10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/seq_mult_param.md
SEQ_MULT_PARAM -- requirements
Module: seq_mult_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand width in bits (legal range 4..64).
REQ-002 The block SHALL have parameter CNT_W, default $clog2(WIDTH+2), iteration counter width.
REQ-003 Port clk, input, 1: single clock; all state SHALL change on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-low reset (rst=0 resets).
REQ-005 Port start, input, 1: request a multiply; sampled only when the block is not busy.
REQ-006 Port is_signed, input, 1: 1 = two's-complement operands, 0 = unsigned operands; captured with start.
REQ-007 Port a, input, WIDTH: multiplicand; captured with start.
REQ-008 Port b, input, WIDTH: multiplier; captured with start.
REQ-009 Port p, output, 2*WIDTH: product, registered, held until the next completion.
REQ-010 Port busy, output, 1: high while an operation is in progress.
REQ-011 Port done, output, 1: single-cycle pulse marking that p has just been updated.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE, with reset state IDLE.
REQ-013 In IDLE or DONE, start=1 at a rising edge (E0) SHALL capture a, b and is_signed, clear the accumulator, load counter=WIDTH+1, and enter RUN.
REQ-014 Operands SHALL be extended to WIDTH+1 bits: sign-extended if is_signed=1, zero-extended otherwise.
REQ-015 RUN SHALL perform one radix-2 Booth step per cycle on the extended operands (add, subtract or no-op, then arithmetic right shift), for exactly WIDTH+1 steps.
REQ-016 On the edge that completes the last step (E0+WIDTH+1), the FSM SHALL write the low 2*WIDTH bits of the result to p, enter DONE, and drive done=1 for that one cycle.
REQ-017 The latency SHALL therefore be a fixed WIDTH+1 cycles from the capture edge to done, independent of operand values (33 for WIDTH=32).
REQ-018 DONE SHALL last exactly one cycle; without start it SHALL return to IDLE, and with start=1 it SHALL accept a back-to-back operation (REQ-013).
REQ-019 busy SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-020 start=1 while in RUN SHALL be ignored, and changes to a, b and is_signed during RUN SHALL NOT affect the result.
REQ-021 p SHALL equal the exact mathematical product for all operand pairs in both modes, including signed -2^(WIDTH-1) * -2^(WIDTH-1) and unsigned (2^WIDTH-1)^2, with no overflow.
REQ-022 A zero operand SHALL still take the full latency and produce p=0.

Reset
REQ-023 When rst=0, asynchronously: state=IDLE, p=0, busy=0, done=0, counter=0, and operand and accumulator registers cleared.
REQ-024 Reset asserted during RUN SHALL abort the operation, with no done pulse and p=0.
REQ-025 After rst is released, the first rising edge with start=1 SHALL begin a new operation normally.

Structure
REQ-026 The shared package mult_pkg SHALL hold the FSM state encoding localparams (IDLE, RUN, DONE) and the counter-width helper function.
REQ-027 The Booth step (add/sub/no-op selection plus arithmetic shift of the (2*WIDTH+3)-bit accumulator) SHALL be a combinational sub-module named booth_step.
REQ-028 The top level SHALL contain only the FSM, the counter and the registers.

Verification
REQ-029 Signed, WIDTH=32: a=20, b=75 -> done exactly 33 cycles after the start edge; p=1500.
REQ-030 Signed: a=0xFFFFFFD5, b=0xFFFFFFD0 -> p=2064; then a=23, b=0xFFFFFFF1 -> p=0xFFFFFFFFFFFFFEA7 (accepted back-to-back from DONE).
REQ-031 Unsigned: a=0xFFFFFFFF, b=0xFFFFFFFF -> p=0xFFFFFFFE00000001; the same operands signed -> p=1.
REQ-032 WIDTH=8 instance, signed: a=0x80, b=0x80 -> p=16384; unsigned: a=0x80, b=0x80 -> p=16384; latency 9 cycles.
REQ-033 Start a=125, b=0xFFFFFFEE (signed), then pulse start with a=7, b=7 at cycle 10 -> ignored; p=0xFFFFFFFFFFFFF736 at cycle 33.
REQ-034 Assert rst=0 at cycle 15 of an operation -> p=0, busy=0, no done pulse; the next start with a=10, b=1 -> p=10.
